mo_arb: RTL and testbench
=========================

MO_ARB -- requirements
Module: mo_arb

Interface
REQ-001 Parameter N_REQ, default 5, number of requesters sharing the 5-way output mixer; the gnt width SHALL match the mixer select width.
REQ-002 Parameter MAX_HOLD, default 16, maximum grant length in cycles while another requester is waiting.
REQ-003 Parameter HOLD_W, default 5, hold-counter width; SHALL satisfy 2**HOLD_W > MAX_HOLD.
REQ-004 wb_clk_i  in  1  sole clock; all state SHALL update on its rising edge.
REQ-005 wb_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 req  in  N_REQ  per-requester request, level, held until granted.
REQ-007 last  in  N_REQ  per-requester final-cycle marker, qualified by own gnt bit.
REQ-008 gnt  out  N_REQ  registered one-hot grant that drives the mixer select.
REQ-009 gnt_id  out  3  binary index of the granted requester; 0 when gnt is 0.
REQ-010 busy  out  1  high while in GRANT.
REQ-011 timeout  out  1  one-cycle pulse when a grant is force-released by MAX_HOLD.

Function
REQ-012 FSM states SHALL be IDLE, GRANT and GAP.
REQ-013 In IDLE and GAP, gnt SHALL be 0.
REQ-014 In IDLE and GAP, if any req bit is high, the picked requester's gnt bit SHALL rise on the next edge and the state SHALL go to GRANT; otherwise the state SHALL go to IDLE.
REQ-015 Latency from req rising in IDLE to gnt high SHALL be exactly 1 cycle.
REQ-016 Pick SHALL be round-robin: search starts at ptr+1 and wraps from N_REQ-1 to 0; ptr is the index of the most recently released requester.
REQ-017 In GRANT, gnt SHALL stay constant and the hold counter SHALL increment each cycle, starting at 0 on entry.
REQ-018 Release SHALL occur when any of these holds for granted index k: last[k]=1; req[k]=0; or counter=MAX_HOLD-1 with any other req bit high.
REQ-019 On release, the state SHALL go to GAP for exactly 1 cycle with gnt=0, and ptr SHALL be set to k.
REQ-020 GAP guarantees one empty mixer-select cycle between owners; back-to-back grants to different requesters SHALL never occur.
REQ-021 If the counter reaches MAX_HOLD-1 and no other requester is waiting, the grant SHALL continue and the counter SHALL wrap to 0; no timeout pulse.
REQ-022 timeout SHALL pulse only on the counter-triggered release cycle; if last[k] or a drop of req[k] coincides, timeout SHALL stay 0.
REQ-023 last bits of non-granted requesters SHALL be ignored.
REQ-024 gnt SHALL always be one-hot or zero.
REQ-025 gnt_id SHALL be registered coincident with gnt.

Reset
REQ-026 While wb_rst_n=0, the following SHALL hold asynchronously: state=IDLE, gnt=0, gnt_id=0, busy=0, timeout=0, counter=0, ptr=N_REQ-1 (requester 0 wins first).
REQ-027 Reset asserted mid-GRANT SHALL drop gnt immediately, without a GAP cycle.
REQ-028 After deassertion, arbitration SHALL resume on the first clock edge.

Structure
REQ-029 Package mo_pkg SHALL hold N_REQ, ID_W=3, the state enum and the default MAX_HOLD.
REQ-030 Sub-module mo_rr_pick SHALL hold the combinational round-robin picker: inputs req and ptr; outputs a valid flag and the picked index.
REQ-031 The FSM, hold counter and output registers SHALL stay in mo_arb; the target size is 120-400 RTL lines.

Verification
REQ-032 Reset, then req=5'b00001 -> gnt=00001 after 1 cycle; last[0] pulse -> 1 GAP cycle with gnt=0, then IDLE.
REQ-033 req=5'b11111 held, each grantee pulses last on its 3rd cycle -> grant order 0,1,2,3,4,0; a gnt=0 GAP cycle between every pair.
REQ-034 req=5'b00011, requester 0 never asserts last, MAX_HOLD=16 -> gnt 0 held 16 cycles, timeout pulses once, GAP, then gnt=00010.
REQ-035 Only req[2] held for 40 cycles with no last -> gnt 00100 held for all 40 cycles, no timeout; counter wraps without release.
REQ-036 wb_rst_n driven low mid-GRANT (gnt=01000) -> gnt=0 asynchronously; after release, with req=5'b01001 -> requester 0 granted first.
REQ-037 last[3] pulsed while gnt=00001 -> ignored; grant to requester 0 continues unchanged.

Source files
------------

// File: rtl/mo_pkg.sv
// Shared constants and state encoding for the multi-owner mixer arbiter.
package mo_pkg;

  localparam int unsigned N_REQ        = 5;
  localparam int unsigned ID_W         = 3;
  localparam int unsigned MAX_HOLD_DEF = 16;
  localparam int unsigned HOLD_W_DEF   = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

endpackage

// File: rtl/mo_rr_pick.sv
// Combinational round-robin picker: first requester after ptr, wrapping at N_REQ-1.
module mo_rr_pick #(
  parameter int unsigned N_REQ = mo_pkg::N_REQ,
  parameter int unsigned ID_W  = mo_pkg::ID_W
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic             vld,
  output logic [ID_W-1:0]  idx
);

  logic [ID_W-1:0] cand;

  // Scan ptr+1 .. ptr+N_REQ (mod N_REQ); the first set bit wins.
  always_comb begin
    vld  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      cand = ID_W'((32'(ptr) + i) % N_REQ);
      if (!vld && req[cand]) begin
        vld = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/mo_arb.sv
// Round-robin arbiter for a shared output mixer, with a guaranteed empty
// select cycle between owners and a hold limit while others are waiting.
module mo_arb #(
  parameter int unsigned N_REQ    = mo_pkg::N_REQ,
  parameter int unsigned MAX_HOLD = mo_pkg::MAX_HOLD_DEF,
  parameter int unsigned HOLD_W   = mo_pkg::HOLD_W_DEF
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        last,
  output logic [N_REQ-1:0]        gnt,
  output logic [mo_pkg::ID_W-1:0] gnt_id,
  output logic                    busy,
  output logic                    timeout
);

  import mo_pkg::*;

  state_e            state_q, state_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic [ID_W-1:0]   ptr_q, ptr_d, gnt_id_d, pick_idx;
  logic [N_REQ-1:0]  gnt_d;
  logic              busy_d, timeout_d, pick_vld;
  logic              last_hit, req_hold, others_wait, at_max, hold_rel;

  mo_rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .req (req),
    .ptr (ptr_q),
    .vld (pick_vld),
    .idx (pick_idx)
  );

  // Release qualifiers; masking with gnt ignores last bits of non-owners.
  assign last_hit    = |(gnt & last);
  assign req_hold    = |(gnt & req);
  assign others_wait = |(req & ~gnt);
  assign at_max      = (cnt_q == HOLD_W'(MAX_HOLD - 1));
  assign hold_rel    = at_max & others_wait;

  // State register.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  // Next state and next values of every registered output.
  always_comb begin
    state_d   = state_q;
    gnt_d     = '0;
    gnt_id_d  = '0;
    busy_d    = 1'b0;
    timeout_d = 1'b0;
    cnt_d     = '0;
    ptr_d     = ptr_q;
    case (state_q)
      ST_IDLE, ST_GAP: begin
        if (pick_vld) begin
          state_d  = ST_GRANT;
          gnt_d    = N_REQ'(1) << pick_idx;
          gnt_id_d = pick_idx;
          busy_d   = 1'b1;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (last_hit || !req_hold || hold_rel) begin
          state_d   = ST_GAP;
          ptr_d     = gnt_id;
          timeout_d = hold_rel & ~last_hit & req_hold;
        end else begin
          gnt_d    = gnt;
          gnt_id_d = gnt_id;
          busy_d   = 1'b1;
          cnt_d    = at_max ? '0 : cnt_q + HOLD_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output, hold-counter and round-robin pointer registers.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      gnt     <= '0;
      gnt_id  <= '0;
      busy    <= 1'b0;
      timeout <= 1'b0;
      cnt_q   <= '0;
      ptr_q   <= ID_W'(N_REQ - 1);
    end else begin
      gnt     <= gnt_d;
      gnt_id  <= gnt_id_d;
      busy    <= busy_d;
      timeout <= timeout_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

endmodule

// File: tb/tb_mo_arb.sv
// Directed bench for mo_arb with hand-computed expectations.
module tb_mo_arb;

  logic       clk;
  logic       rst_n;
  logic [4:0] req;
  logic [4:0] last;
  logic [4:0] gnt;
  logic [2:0] gnt_id;
  logic       busy;
  logic       timeout;

  int total = 0;
  int bad   = 0;

  mo_arb dut (
    .wb_clk_i (clk),
    .wb_rst_n (rst_n),
    .req      (req),
    .last     (last),
    .gnt      (gnt),
    .gnt_id   (gnt_id),
    .busy     (busy),
    .timeout  (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply reset for two cycles, release on a falling edge.
  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    last  = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (gnt !== 5'b00000) begin bad++; $display("FAIL reset_gnt got=%b exp=00000", gnt); end
    total++; if (gnt_id !== 3'd0) begin bad++; $display("FAIL reset_gnt_id got=%0d exp=0", gnt_id); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%b exp=0", timeout); end
  endtask

  // Single requester: one-cycle latency, last -> one GAP cycle -> idle.
  task automatic test_single();
    req = 5'b00001;
    @(negedge clk);
    total++; if (gnt !== 5'b00001) begin bad++; $display("FAIL single_gnt got=%b exp=00001", gnt); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%b exp=1", busy); end
    last = 5'b00001;
    @(negedge clk);
    total++; if (gnt !== 5'b00000) begin bad++; $display("FAIL single_gap got=%b exp=00000", gnt); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_gap_busy got=%b exp=0", busy); end
    req  = '0;
    last = '0;
    @(negedge clk);
    total++; if (gnt !== 5'b00000) begin bad++; $display("FAIL single_idle got=%b exp=00000", gnt); end
  endtask

  // All requesting, each owner ends on its 3rd cycle: order 0,1,2,3,4,0.
  task automatic test_rr_order();
    logic [2:0] order [6];
    logic [4:0] exp_g;
    order = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
    do_reset();
    req = 5'b11111;
    for (int n = 0; n < 6; n++) begin
      exp_g = 5'b00001 << order[n];
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        total++; if (gnt !== exp_g) begin bad++; $display("FAIL rr_gnt n=%0d c=%0d got=%b exp=%b", n, c, gnt, exp_g); end
        total++; if (gnt_id !== order[n]) begin bad++; $display("FAIL rr_id n=%0d got=%0d exp=%0d", n, gnt_id, order[n]); end
      end
      last = exp_g;
      @(negedge clk);
      last = '0;
      if (n == 5) req = '0;
      total++; if (gnt !== 5'b00000) begin bad++; $display("FAIL rr_gap n=%0d got=%b exp=00000", n, gnt); end
      total++; if (timeout !== 1'b0) begin bad++; $display("FAIL rr_timeout n=%0d got=%b exp=0", n, timeout); end
    end
    @(negedge clk);
    total++; if (gnt !== 5'b00000) begin bad++; $display("FAIL rr_idle got=%b exp=00000", gnt); end
  endtask

  // Owner 0 never finishes while 1 waits: 16 cycles, timeout, GAP, then 1.
  task automatic test_timeout();
    do_reset();
    req = 5'b00011;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      total++; if (gnt !== 5'b00001) begin bad++; $display("FAIL to_hold c=%0d got=%b exp=00001", c, gnt); end
      total++; if (timeout !== 1'b0) begin bad++; $display("FAIL to_early c=%0d got=%b exp=0", c, timeout); end
    end
    @(negedge clk);
    total++; if (gnt !== 5'b00000) begin bad++; $display("FAIL to_gap got=%b exp=00000", gnt); end
    total++; if (timeout !== 1'b1) begin bad++; $display("FAIL to_pulse got=%b exp=1", timeout); end
    @(negedge clk);
    total++; if (gnt !== 5'b00010) begin bad++; $display("FAIL to_next got=%b exp=00010", gnt); end
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL to_pulse_len got=%b exp=0", timeout); end
    req = '0;
    @(negedge clk);
    total++; if (gnt !== 5'b00000) begin bad++; $display("FAIL to_drop got=%b exp=00000", gnt); end
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL to_drop_pulse got=%b exp=0", timeout); end
    @(negedge clk);
  endtask

  // Lone requester past MAX_HOLD: counter wraps, grant never released.
  task automatic test_wrap();
    do_reset();
    req = 5'b00100;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      total++; if (gnt !== 5'b00100) begin bad++; $display("FAIL wrap_gnt c=%0d got=%b exp=00100", c, gnt); end
      total++; if (timeout !== 1'b0) begin bad++; $display("FAIL wrap_timeout c=%0d got=%b exp=0", c, timeout); end
    end
    req = '0;
    @(negedge clk);
    total++; if (gnt !== 5'b00000) begin bad++; $display("FAIL wrap_release got=%b exp=00000", gnt); end
    @(negedge clk);
  endtask

  // last from a non-owner is ignored; leaves ptr at 0 on release.
  task automatic test_last_ignored();
    do_reset();
    req = 5'b00001;
    @(negedge clk);
    total++; if (gnt !== 5'b00001) begin bad++; $display("FAIL li_gnt got=%b exp=00001", gnt); end
    last = 5'b01000;
    @(negedge clk);
    last = '0;
    total++; if (gnt !== 5'b00001) begin bad++; $display("FAIL li_kept got=%b exp=00001", gnt); end
    @(negedge clk);
    total++; if (gnt !== 5'b00001) begin bad++; $display("FAIL li_kept2 got=%b exp=00001", gnt); end
    last = 5'b00001;
    @(negedge clk);
    last = '0;
    req  = '0;
    total++; if (gnt !== 5'b00000) begin bad++; $display("FAIL li_gap got=%b exp=00000", gnt); end
    @(negedge clk);
  endtask

  // Reset mid-grant drops gnt at once and restores the pointer so 0 wins.
  task automatic test_reset_mid_grant();
    req = 5'b01000;
    @(negedge clk);
    total++; if (gnt !== 5'b01000) begin bad++; $display("FAIL rm_gnt got=%b exp=01000", gnt); end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++; if (gnt !== 5'b00000) begin bad++; $display("FAIL rm_async_gnt got=%b exp=00000", gnt); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rm_async_busy got=%b exp=0", busy); end
    total++; if (gnt_id !== 3'd0) begin bad++; $display("FAIL rm_async_id got=%0d exp=0", gnt_id); end
    @(negedge clk);
    req   = 5'b01001;
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (gnt !== 5'b00001) begin bad++; $display("FAIL rm_first got=%b exp=00001", gnt); end
    total++; if (gnt_id !== 3'd0) begin bad++; $display("FAIL rm_first_id got=%0d exp=0", gnt_id); end
    last = 5'b00001;
    @(negedge clk);
    last = '0;
    req  = 5'b01000;
    total++; if (gnt !== 5'b00000) begin bad++; $display("FAIL rm_gap got=%b exp=00000", gnt); end
    @(negedge clk);
    total++; if (gnt !== 5'b01000) begin bad++; $display("FAIL rm_second got=%b exp=01000", gnt); end
    total++; if (gnt_id !== 3'd3) begin bad++; $display("FAIL rm_second_id got=%0d exp=3", gnt_id); end
    req = '0;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    req   = '0;
    last  = '0;
    test_reset();
    test_single();
    test_rr_order();
    test_timeout();
    test_wrap();
    test_last_ignored();
    test_reset_mid_grant();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
